// File: rtl/math_pipelined_deskew_if.sv
// Handshake bundle between a skewed-chunk ALU producer, the deskew FIFO and its consumer.
// The master side drives launches and consumer readiness; the slave side is the deskew block.
interface math_pipelined_deskew_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_start;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    modport master (
        output in_start,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  overflow
    );

    modport slave (
        input  in_start,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output overflow
    );
endinterface

// File: rtl/math_pipelined_deskew.sv
// Realigns chunk-skewed ALU results into whole words and queues them in a small FIFO.
// A credit count (queued + in-flight words) gates in_ready so every accepted launch has a slot.
module math_pipelined_deskew #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    math_pipelined_deskew_if.slave bus
);

    localparam int unsigned ALU_WIDTH   = (LATENCY == 0) ? WIDTH
                                                         : (WIDTH + LATENCY - 1) / LATENCY;
    localparam int unsigned CHUNK_COUNT = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
    localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);

    localparam logic [CNT_W:0]   DepthW   = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LastSlot = PTR_W'(DEPTH - 1);

    // Bits belonging to chunk k; the final chunk is naturally clipped at WIDTH.
    function automatic logic [WIDTH-1:0] chunk_mask(int unsigned k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = ((i / ALU_WIDTH) == k);
        end
        return m;
    endfunction

    // Bits of all chunks below chunk k.
    function automatic logic [WIDTH-1:0] low_mask(int unsigned k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (i < k * ALU_WIDTH);
        end
        return m;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == LastSlot) ? '0 : p + 1'b1;
    endfunction

    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   used;
    logic             pop;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             overflow_q;

    assign accept = bus.in_start & bus.in_ready;

    if (CHUNK_COUNT > 1) begin : g_deskew
        localparam int unsigned STAGES = CHUNK_COUNT - 1;

        logic [STAGES-1:0] sdly_q;
        logic [WIDTH-1:0]  stage_q [STAGES];

        // Stage s holds chunks 0..s of the word launched s+1 cycles ago.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sdly_q <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    stage_q[s] <= '0;
                end
            end else begin
                sdly_q[0]  <= accept;
                stage_q[0] <= bus.in_data & chunk_mask(0);
                for (int s = 1; s < STAGES; s++) begin
                    sdly_q[s]  <= sdly_q[s-1];
                    stage_q[s] <= (stage_q[s-1] & low_mask(s)) | (bus.in_data & chunk_mask(s));
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int s = 0; s < STAGES; s++) begin
                inflight = inflight + CNT_W'(sdly_q[s]);
            end
        end

        // Last chunk is taken straight from the input in its own cycle.
        assign wr_en   = sdly_q[STAGES-1];
        assign wr_data = (stage_q[STAGES-1] & low_mask(STAGES))
                       | (bus.in_data & chunk_mask(STAGES));
    end else begin : g_direct
        assign inflight = '0;
        assign wr_en    = accept;
        assign wr_data  = bus.in_data;
    end

    assign used         = {1'b0, count_q} + {1'b0, inflight};
    assign bus.in_ready = (used < DepthW);
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;
    assign pop           = bus.out_valid & bus.out_ready;

    // out_data is registered and tracks the head; it keeps its last value once empty.
    always_comb begin
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        out_data_d = out_data_q;
        if (count_d != '0) begin
            out_data_d = (wr_en && (rd_ptr_d == wr_ptr_q)) ? wr_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_q | (bus.in_start & ~bus.in_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_math_pipelined_deskew.sv
// Directed bench for math_pipelined_deskew: an 8-bit/4-chunk/5-deep instance and an
// 8-bit zero-latency instance, with hand-computed expected words and cycle numbers.
module tb_math_pipelined_deskew;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    math_pipelined_deskew_if #(.WIDTH(8)) a_if ();
    math_pipelined_deskew_if #(.WIDTH(8)) z_if ();

    math_pipelined_deskew #(.WIDTH(8), .LATENCY(4), .DEPTH(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    math_pipelined_deskew #(.WIDTH(8), .LATENCY(0), .DEPTH(2)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (z_if)
    );

    // Words scheduled for the skewed input stream of dut_a.
    int         w_start [8];
    logic [7:0] w_val   [8];
    int         w_num = 0;

    function automatic logic [7:0] cycle_data(int c);
        logic [7:0] d;
        logic [7:0] m;
        int         k;
        d = 8'($urandom);
        for (int i = 0; i < w_num; i++) begin
            k = c - w_start[i];
            if (k >= 0 && k < 4) begin
                m = 8'h03 << (2 * k);
                d = (d & ~m) | (w_val[i] & m);
            end
        end
        return d;
    endfunction

    // A write into a full FIFO must never happen.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut_a.wr_en === 1'b1 && dut_a.count_q == 5) begin
            fails++;
            $display("FAIL write_full_a: write with count=%0d, required count<5", dut_a.count_q);
        end
        if (rst_n === 1'b1 && dut_z.wr_en === 1'b1 && dut_z.count_q == 2) begin
            fails++;
            $display("FAIL write_full_z: write with count=%0d, required count<2", dut_z.count_q);
        end
    end

    task automatic test_reset();
        rst_n          = 1'b0;
        a_if.in_start  = 1'b0;
        a_if.in_data   = 8'h00;
        a_if.out_ready = 1'b1;
        z_if.in_start  = 1'b0;
        z_if.in_data   = 8'h00;
        z_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (a_if.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b, required 0", a_if.out_valid);
        end
        tests++;
        if (a_if.out_data !== 8'h00) begin
            fails++; $display("FAIL reset_data: got %h, required 00", a_if.out_data);
        end
        tests++;
        if (a_if.overflow !== 1'b0) begin
            fails++; $display("FAIL reset_overflow: got %b, required 0", a_if.overflow);
        end
        tests++;
        if (a_if.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b, required 1", a_if.in_ready);
        end
        tests++;
        if (z_if.out_valid !== 1'b0 || z_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_z: got valid=%b ready=%b, required 0/1",
                     z_if.out_valid, z_if.in_ready);
        end
    endtask

    // Single word 0xB4 with random garbage outside each chunk window.
    task automatic test_single();
        w_num = 1; w_start[0] = 0; w_val[0] = 8'hB4;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            a_if.in_start = (c == 0);
            a_if.in_data  = cycle_data(c);
            @(negedge clk);
            tests++;
            if (a_if.out_valid !== (c == 4)) begin
                fails++;
                $display("FAIL single_valid c%0d: got %b, required %b", c, a_if.out_valid, c == 4);
            end
            if (c >= 4) begin
                tests++;
                if (a_if.out_data !== 8'hB4) begin
                    fails++;
                    $display("FAIL single_data c%0d: got %h, required b4", c, a_if.out_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w [3];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        w_num = 3;
        for (int i = 0; i < 3; i++) begin
            w_start[i] = i; w_val[i] = exp_w[i];
        end
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            a_if.in_start = (c < 3);
            a_if.in_data  = cycle_data(c);
            @(negedge clk);
            tests++;
            if (a_if.out_valid !== (c >= 4 && c <= 6)) begin
                fails++;
                $display("FAIL b2b_valid c%0d: got %b, required %b", c, a_if.out_valid,
                         (c >= 4 && c <= 6));
            end
            if (c >= 4 && c <= 6) begin
                tests++;
                if (a_if.out_data !== exp_w[c-4]) begin
                    fails++;
                    $display("FAIL b2b_data c%0d: got %h, required %h", c, a_if.out_data,
                             exp_w[c-4]);
                end
            end
        end
    endtask

    // Stalled consumer: launch whenever in_ready, expect exactly DEPTH=5 accepted launches.
    task automatic test_fill();
        int accepted = 0;
        w_num = 5;
        w_val[0] = 8'hA1; w_val[1] = 8'h3C; w_val[2] = 8'hE7; w_val[3] = 8'h58; w_val[4] = 8'h96;
        for (int i = 0; i < 5; i++) w_start[i] = i;
        a_if.out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            tests++;
            if (a_if.in_ready !== (c < 5)) begin
                fails++;
                $display("FAIL fill_in_ready c%0d: got %b, required %b", c, a_if.in_ready, c < 5);
            end
            a_if.in_start = a_if.in_ready;
            a_if.in_data  = cycle_data(c);
            if (a_if.in_start) accepted++;
        end
        @(negedge clk);
        tests++;
        if (accepted != 5) begin
            fails++; $display("FAIL fill_accepted: got %0d, required 5", accepted);
        end
        tests++;
        if (a_if.overflow !== 1'b0) begin
            fails++; $display("FAIL fill_overflow: got %b, required 0", a_if.overflow);
        end
        tests++;
        if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'hA1) begin
            fails++;
            $display("FAIL fill_head: got valid=%b data=%h, required 1/a1",
                     a_if.out_valid, a_if.out_data);
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            a_if.in_start = (c == 0);
            a_if.in_data  = 8'($urandom);
            if (c == 0) begin
                tests++;
                if (a_if.in_ready !== 1'b0) begin
                    fails++; $display("FAIL ovf_in_ready: got %b, required 0", a_if.in_ready);
                end
            end
            @(negedge clk);
            if (c >= 1) begin
                tests++;
                if (a_if.overflow !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_sticky c%0d: got %b, required 1", c, a_if.overflow);
                end
                tests++;
                if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'hA1 || a_if.in_ready !== 1'b0)
                begin
                    fails++;
                    $display("FAIL ovf_fifo c%0d: got v=%b d=%h r=%b, required 1/a1/0", c,
                             a_if.out_valid, a_if.out_data, a_if.in_ready);
                end
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp_w [5];
        exp_w[0] = 8'hA1; exp_w[1] = 8'h3C; exp_w[2] = 8'hE7; exp_w[3] = 8'h58; exp_w[4] = 8'h96;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            a_if.out_ready = 1'b1;
            a_if.in_start  = 1'b0;
            @(negedge clk);
            tests++;
            if (a_if.out_valid !== (c < 5)) begin
                fails++;
                $display("FAIL drain_valid c%0d: got %b, required %b", c, a_if.out_valid, c < 5);
            end
            if (c < 5) begin
                tests++;
                if (a_if.out_data !== exp_w[c]) begin
                    fails++;
                    $display("FAIL drain_data c%0d: got %h, required %h", c, a_if.out_data,
                             exp_w[c]);
                end
            end
            tests++;
            if (a_if.in_ready !== (c >= 1)) begin
                fails++;
                $display("FAIL drain_in_ready c%0d: got %b, required %b", c, a_if.in_ready, c >= 1);
            end
            tests++;
            if (a_if.overflow !== 1'b1) begin
                fails++; $display("FAIL drain_overflow c%0d: got %b, required 1", c, a_if.overflow);
            end
        end
    endtask

    // Reset in cycle 6 with 3 words queued and 2 still in the deskew pipeline.
    task automatic test_reset_mid();
        w_num = 5;
        w_val[0] = 8'hC3; w_val[1] = 8'h7E; w_val[2] = 8'h19; w_val[3] = 8'hD2; w_val[4] = 8'h4B;
        for (int i = 0; i < 5; i++) w_start[i] = i;
        a_if.out_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            a_if.in_start = (c < 5);
            a_if.in_data  = cycle_data(c);
            rst_n         = (c != 6);
            @(negedge clk);
            if (c == 6) begin
                tests++;
                if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'hC3) begin
                    fails++;
                    $display("FAIL rstmid_pre: got v=%b d=%h, required 1/c3",
                             a_if.out_valid, a_if.out_data);
                end
            end
            if (c == 7) begin
                tests++;
                if (a_if.overflow !== 1'b0) begin
                    fails++; $display("FAIL rstmid_overflow: got %b, required 0", a_if.overflow);
                end
            end
            if (c >= 7) begin
                tests++;
                if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL rstmid_post c%0d: got v=%b r=%b, required 0/1", c,
                             a_if.out_valid, a_if.in_ready);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency0();
        z_if.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                tests++;
                if (z_if.in_ready !== 1'b1) begin
                    fails++; $display("FAIL lat0_in_ready: got %b, required 1", z_if.in_ready);
                end
            end
            z_if.in_start = (c == 0);
            z_if.in_data  = (c == 0) ? 8'h5A : 8'($urandom);
            @(negedge clk);
            tests++;
            if (z_if.out_valid !== (c == 1)) begin
                fails++;
                $display("FAIL lat0_valid c%0d: got %b, required %b", c, z_if.out_valid, c == 1);
            end
            if (c >= 1) begin
                tests++;
                if (z_if.out_data !== 8'h5A) begin
                    fails++;
                    $display("FAIL lat0_data c%0d: got %h, required 5a", c, z_if.out_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_overflow();
        test_drain();
        test_reset_mid();
        test_latency0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/math_pipelined_deskew.md
Name: math_pipelined_deskew

Overview:
- Receive-side companion to the chunked pipelined ALU.
- The ALU emits results skewed: chunk k of a result word is valid k cycles after chunk 0.
- This block realigns skewed chunks into a coherent WIDTH-bit word and queues it in a small FIFO with a valid/ready output.
- It exports a credit-style in_ready so the producer only launches words that are guaranteed a FIFO slot.

Parameters:
- WIDTH, 32, result word width in bits.
- LATENCY, 4, must match the producing ALU.
  - ALU_WIDTH = LATENCY==0 ? WIDTH : ceil(WIDTH/LATENCY).
  - CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH).
  - LAST_CHUNK_SIZE = WIDTH%ALU_WIDTH==0 ? ALU_WIDTH : WIDTH%ALU_WIDTH.
- DEPTH, 4, output FIFO entries (>=1). DEPTH >= CHUNK_COUNT+1 is needed for one word per cycle sustained.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- in_start  input  1  chunk 0 of a new word is on in_data this cycle.
- in_data  input  WIDTH  skewed data; chunk k (bits k*ALU_WIDTH upward) is valid CHUNK_COUNT-independent k cycles after its in_start.
- in_ready  output  1  a launch in this cycle is guaranteed a FIFO slot.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the head word.
- overflow  output  1  sticky: in_start was seen while in_ready=0.

Behaviour:
- Reset (rst_n=0 at posedge), all applied regardless of in-flight words:
  - out_valid=0, out_data=0, overflow=0.
  - FIFO emptied.
  - Start delay line cleared; all in-flight words discarded.
  - Deskew registers cleared.
  - in_ready=1 from the first cycle after reset release.
- Start tracking: delay line sdly[0..CHUNK_COUNT-1]. sdly[0] <= in_start & in_ready; sdly[k] <= sdly[k-1].
- Deskew: chunk k passes through CHUNK_COUNT-1-k register stages, so the last chunk is used directly. All chunks of one word therefore align on cycle t+CHUNK_COUNT-1.
- Write: at the posedge ending cycle t+CHUNK_COUNT-1 of an accepted launch at t, the aligned word is written to the FIFO tail.
- Latency: a launch at cycle t into an empty FIFO gives out_valid=1 in cycle t+CHUNK_COUNT.
- CHUNK_COUNT==1 (LATENCY 0 or 1): no deskew stages; the word is written at the posedge ending cycle t; out_valid in cycle t+1.
- Throughput: one launch per cycle; back-to-back launches never mix chunks between words.
- Credit rule:
  - inflight = number of set bits in sdly[0..CHUNK_COUNT-2].
  - in_ready = (fifo_count + inflight + (in_start_accepted_last ? 0 : 0)) < DEPTH, evaluated from registered state only.
  - A pop in the current cycle frees its credit starting the next cycle (conservative, no combinational out_ready->in_ready path).
- Violation: in_start with in_ready=0 is dropped (no write, no delay-line entry) and sets overflow. overflow clears only on reset.
- FIFO:
  - out_valid = fifo_count!=0.
  - Pop when out_valid & out_ready.
  - Simultaneous write and pop: count unchanged, pointers both advance.
  - Write to a full FIFO cannot occur by construction. A bench assertion must check that it never happens.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- out_data holds its value while out_valid & !out_ready. out_data is don't-care-stable, holding the last value, when empty.
- Chunk bits outside the current valid window are ignored. The last chunk uses only LAST_CHUNK_SIZE bits.

Test Plan:
- WIDTH=8, LATENCY=4 (ALU_WIDTH=2, CHUNK_COUNT=4), DEPTH=5, out_ready=1:
  - Launch at cycle 0, chunks presented at cycles 0..3 forming 0xB4 -> out_valid=1, out_data=0xB4 at cycle 4 only.
  - Garbage driven on non-window chunks must not appear in the output.
- Back-to-back launches at cycles 0,1,2 with words 0x11, 0x22, 0x33, each correctly skewed -> out_data 0x11/0x22/0x33 on cycles 4/5/6, no mixing.
- out_ready=0, launch every cycle while in_ready -> exactly 5 accepted launches. in_ready falls once fifo_count+inflight reaches 5. No overflow.
- Continuing the previous case: force in_start while in_ready=0 -> overflow=1 and stays 1. FIFO contents unchanged.
- Continuing: raise out_ready -> 5 words drain in order. in_ready returns 1 the cycle after the first pop.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 2 words in flight and 3 queued -> next cycle out_valid=0, overflow=0, in_ready=1. No stale word ever emerges.
- LATENCY=0, WIDTH=8: launch 0x5A at cycle 0 -> out_data=0x5A, out_valid=1 at cycle 1.
